// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   fetch_state_e  fetch controller states
//   NOP_WORD       word presented to IF/ID when nothing valid is delivered
//   PC_INCR        sequential fetch stride in bytes
//   word_align()   clears the byte-offset bits of an address
package fetch_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,  // held in / just leaving reset, no request issued
    REQ   = 2'd1,  // live request outstanding to program memory
    HOLD  = 2'd2,  // fetched word parked while the hazard unit stalls
    DRAIN = 2'd3   // request outstanding but its data belongs to a squashed path
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
  localparam logic [31:0] PC_INCR    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Instructions are word aligned; the low two address bits carry no meaning.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register with its next-PC selection.
// Latency: one cycle from a load/increment control to the new PC on pc_o.
// Backpressure: none; the PC holds whenever no control is asserted.
//
// Ports:
//   clock, nreset      clock and synchronous active-low reset (PC <= RESET_PC)
//   load_branch_i      take branch_addr_i (aligned) as the next PC
//   load_target_i      take target_i as the next PC
//   incr_i             advance the PC by one instruction word
//   branch_addr_i      redirect target straight from the branch unit
//   target_i           redirect target saved while a stale request drained
//   pc_o               current PC, also the memory read address
module program_counter
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        load_branch_i,
  input  logic        load_target_i,
  input  logic        incr_i,
  input  logic [31:0] branch_addr_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // The controller never asserts more than one control per cycle; the
  // priority order below only makes the mux well defined if it did.
  always_comb begin
    pc_d = pc_q;
    if (load_branch_i) begin
      pc_d = word_align(branch_addr_i);
    end else if (load_target_i) begin
      pc_d = target_i;
    end else if (incr_i) begin
      // Plain 32-bit add: 32'hFFFFFFFC rolls over to 0.
      pc_d = pc_q + PC_INCR;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC ownership, program-memory request/ack, IF/ID delivery.
// Latency: imem_ack in cycle N gives instruction_out in cycle N+1; one word per clock with zero-wait memory.
// Backpressure: stall parks an acked word in a one-entry hold buffer and stops new requests; take_branch overrides stall.
//
// Ports:
//   clock, nreset          clock and synchronous active-low reset
//   stall                  hazard-unit hold of the PC and any fetched word
//   take_branch            redirect request, sampled every cycle
//   branch_addr            redirect target (low two bits ignored)
//   imem_req / imem_addr   read request and address to program memory
//   imem_ack / imem_rdata  read completion and data from program memory
//   instruction_out        word to IF/ID, NOP_WORD when nothing is delivered
//   pc_out                 PC of the last delivered word (holds otherwise)
//   take_branch_addr_out   one-cycle pulse after each accepted redirect
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        stall,
  input  logic        take_branch,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        take_branch_addr_out
);

  fetch_state_e state_q, state_d;

  logic        imem_req_q,   imem_req_d;
  logic [31:0] instr_q,      instr_d;
  logic [31:0] pc_out_q,     pc_out_d;
  logic        br_pulse_q,   br_pulse_d;
  logic [31:0] hold_buf_q,   hold_buf_d;
  logic [31:0] hold_pc_q,    hold_pc_d;
  logic [31:0] target_q,     target_d;

  logic        pc_load_branch;
  logic        pc_load_target;
  logic        pc_incr;
  logic [31:0] pc;

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_program_counter (
    .clock         (clock),
    .nreset        (nreset),
    .load_branch_i (pc_load_branch),
    .load_target_i (pc_load_target),
    .incr_i        (pc_incr),
    .branch_addr_i (branch_addr),
    .target_i      (target_q),
    .pc_o          (pc)
  );

  // Next-state and next-output decode. Everything computed here is
  // registered in the single sequential block below.
  always_comb begin
    state_d        = state_q;
    instr_d        = NOP_WORD;   // NOP unless a word is delivered this cycle
    pc_out_d       = pc_out_q;
    br_pulse_d     = 1'b0;
    hold_buf_d     = hold_buf_q;
    hold_pc_d      = hold_pc_q;
    target_d       = target_q;
    pc_load_branch = 1'b0;
    pc_load_target = 1'b0;
    pc_incr        = 1'b0;

    case (state_q)
      RST: begin
        // Any ack seen here belongs to a request abandoned by reset.
        state_d = REQ;
      end

      REQ: begin
        if (imem_ack && take_branch) begin
          // The request just completed, so the redirect can go straight
          // into the PC; the returned word is on the wrong path.
          pc_load_branch = 1'b1;
          br_pulse_d     = 1'b1;
        end else if (take_branch) begin
          // Cannot withdraw the request: keep the address on the bus,
          // remember where to go, and throw the data away when it lands.
          target_d   = word_align(branch_addr);
          br_pulse_d = 1'b1;
          state_d    = DRAIN;
        end else if (imem_ack && stall) begin
          hold_buf_d = imem_rdata;
          hold_pc_d  = pc;
          pc_incr    = 1'b1;
          state_d    = HOLD;
        end else if (imem_ack) begin
          instr_d  = imem_rdata;
          pc_out_d = pc;
          pc_incr  = 1'b1;
        end
      end

      HOLD: begin
        if (take_branch) begin
          // The parked word is younger than the branch: drop it.
          pc_load_branch = 1'b1;
          br_pulse_d     = 1'b1;
          state_d        = REQ;
        end else if (!stall) begin
          instr_d  = hold_buf_q;
          pc_out_d = hold_pc_q;
          state_d  = REQ;
        end
      end

      DRAIN: begin
        if (take_branch) begin
          // A newer redirect replaces the saved target. If the stale ack
          // arrives in the same cycle the bus is free, so go there directly.
          target_d   = word_align(branch_addr);
          br_pulse_d = 1'b1;
          if (imem_ack) begin
            pc_load_branch = 1'b1;
            state_d        = REQ;
          end
        end else if (imem_ack) begin
          pc_load_target = 1'b1;
          state_d        = REQ;
        end
      end

      default: begin
        state_d = RST;
      end
    endcase

    // A request is on the bus in both REQ and DRAIN.
    imem_req_d = (state_d == REQ) || (state_d == DRAIN);
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q    <= RST;
      imem_req_q <= 1'b0;
      instr_q    <= NOP_WORD;
      pc_out_q   <= RESET_PC;
      br_pulse_q <= 1'b0;
      hold_buf_q <= NOP_WORD;
      hold_pc_q  <= RESET_PC;
      target_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      imem_req_q <= imem_req_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      br_pulse_q <= br_pulse_d;
      hold_buf_q <= hold_buf_d;
      hold_pc_q  <= hold_pc_d;
      target_q   <= target_d;
    end
  end

  assign imem_req             = imem_req_q;
  assign imem_addr            = pc;   // straight from the PC flop
  assign instruction_out      = instr_q;
  assign pc_out               = pc_out_q;
  assign take_branch_addr_out = br_pulse_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        nreset;
  logic        stall;
  logic        take_branch;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        take_branch_addr_out;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  bit saw_squashed = 1'b0;

  localparam logic [31:0] PAT = 32'hA5A5A5A5;

  always #5 clock = ~clock;

  instruction_fetch dut (
    .clock                (clock),
    .nreset               (nreset),
    .stall                (stall),
    .take_branch          (take_branch),
    .branch_addr          (branch_addr),
    .imem_req             (imem_req),
    .imem_addr            (imem_addr),
    .imem_ack             (imem_ack),
    .imem_rdata           (imem_rdata),
    .instruction_out      (instruction_out),
    .pc_out               (pc_out),
    .take_branch_addr_out (take_branch_addr_out)
  );

  // ---------------------------------------------------------------
  // Reference model: tracks what the fetch stage must be doing in
  // terms of "is a request on the bus", "is its data wanted",
  // "is a word parked" and "where is the next fetch".
  // ---------------------------------------------------------------
  bit          m_running = 1'b0;  // out of reset and fetching
  bit          m_on_bus  = 1'b0;  // a request is visible to memory
  bit          m_unwanted = 1'b0; // that request's data is on a dead path
  bit          m_parked  = 1'b0;  // a word is waiting out a stall
  logic [31:0] m_fetch   = 32'h0; // address being / to be fetched
  logic [31:0] m_dest    = 32'h0; // where to go once the dead request lands
  logic [31:0] m_pword   = 32'h0;
  logic [31:0] m_paddr   = 32'h0;
  logic [31:0] e_word    = 32'h0;
  logic [31:0] e_pc      = 32'h0;
  bit          e_pulse   = 1'b0;

  always @(posedge clock) begin
    e_word  = 32'h0;
    e_pulse = 1'b0;
    if (!nreset) begin
      m_running = 1'b0; m_on_bus = 1'b0; m_unwanted = 1'b0; m_parked = 1'b0;
      m_fetch = 32'h0; e_pc = 32'h0;
    end else if (!m_running) begin
      m_running = 1'b1;
      m_on_bus  = 1'b1;
    end else if (m_parked) begin
      if (take_branch) begin
        m_parked = 1'b0; m_on_bus = 1'b1; e_pulse = 1'b1;
        m_fetch  = {branch_addr[31:2], 2'b00};
      end else if (!stall) begin
        m_parked = 1'b0; m_on_bus = 1'b1;
        e_word = m_pword; e_pc = m_paddr;
      end
    end else if (m_unwanted) begin
      if (take_branch) begin
        e_pulse = 1'b1;
        m_dest  = {branch_addr[31:2], 2'b00};
        if (imem_ack) begin m_fetch = m_dest; m_unwanted = 1'b0; end
      end else if (imem_ack) begin
        m_fetch = m_dest; m_unwanted = 1'b0;
      end
    end else begin
      if (take_branch) begin
        e_pulse = 1'b1;
        if (imem_ack) m_fetch = {branch_addr[31:2], 2'b00};
        else begin m_unwanted = 1'b1; m_dest = {branch_addr[31:2], 2'b00}; end
      end else if (imem_ack) begin
        if (stall) begin
          m_parked = 1'b1; m_on_bus = 1'b0; m_pword = imem_rdata; m_paddr = m_fetch;
        end else begin
          e_word = imem_rdata; e_pc = m_fetch;
        end
        m_fetch = m_fetch + 32'd4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Single compare process: every cycle, DUT against the model.
  always @(negedge clock) begin
    if (check_en) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_on_bus});
      chk("imem_addr", imem_addr, m_fetch);
      chk("instruction_out", instruction_out, e_word);
      chk("pc_out", pc_out, e_pc);
      chk("take_branch_addr_out", {31'b0, take_branch_addr_out}, {31'b0, e_pulse});
      if (instruction_out === 32'hDEADBEEF) saw_squashed = 1'b1;
    end
  end

  // Inputs change just after a falling edge; returns at the next falling edge.
  task automatic drive(input logic r, input logic st, input logic br,
                       input logic [31:0] ba, input logic ak, input logic [31:0] rd);
    nreset = r; stall = st; take_branch = br; branch_addr = ba;
    imem_ack = ak; imem_rdata = rd;
    @(negedge clock);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic fetch_ok();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, m_fetch ^ PAT);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    nreset = 1'b0; stall = 1'b0; take_branch = 1'b0; branch_addr = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;

    // Reset values
    do_reset();
    check_en = 1'b1;
    chk("rst imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst instruction_out", instruction_out, 32'h0);
    chk("rst pc_out", pc_out, 32'h0);
    chk("rst pulse", {31'b0, take_branch_addr_out}, 32'd0);

    // First request one cycle after release, then ack every cycle
    idle();
    chk("first req", {31'b0, imem_req}, 32'd1);
    fetch_ok();
    chk("seq0 instr", instruction_out, 32'hA5A5A5A5);
    chk("seq0 pc", pc_out, 32'h0);
    fetch_ok();
    chk("seq1 instr", instruction_out, 32'hA5A5A5A1);
    chk("seq1 pc", pc_out, 32'h4);
    fetch_ok();
    chk("seq2 instr", instruction_out, 32'hA5A5A5AD);
    chk("seq2 pc", pc_out, 32'h8);

    // Ack delayed three cycles per request
    for (int n = 0; n < 3; n++) begin
      for (int w = 0; w < 3; w++) begin
        idle();
        chk("wait addr", imem_addr, 32'd12 + 32'(n) * 32'd4);
        chk("wait nop", instruction_out, 32'h0);
      end
      fetch_ok();
    end
    chk("slow last instr", instruction_out, 32'hA5A5A5B1);
    chk("slow last pc", pc_out, 32'h14);

    // Reset mid-operation with a request outstanding, then stall at pc=8
    do_reset();
    chk("rerst req", {31'b0, imem_req}, 32'd0);
    idle();
    fetch_ok();
    fetch_ok();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h12345678);
    chk("hold req", {31'b0, imem_req}, 32'd0);
    chk("hold nop", instruction_out, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hold2 req", {31'b0, imem_req}, 32'd0);
    idle();
    chk("release instr", instruction_out, 32'h12345678);
    chk("release pc", pc_out, 32'h8);
    chk("resume addr", imem_addr, 32'hC);
    fetch_ok();
    chk("resume instr", instruction_out, 32'hA5A5A5A9);

    // Redirect while the request to 0x10 is outstanding
    drive(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("drain pulse", {31'b0, take_branch_addr_out}, 32'd1);
    chk("drain addr", imem_addr, 32'h10);
    idle();
    chk("drain pulse off", {31'b0, take_branch_addr_out}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
    chk("stale dropped", instruction_out, 32'h0);
    chk("redirect addr", imem_addr, 32'h100);
    fetch_ok();
    chk("target instr", instruction_out, 32'hA5A5A4A5);
    chk("target pc", pc_out, 32'h100);

    // Redirect with ack in the same cycle, unaligned target
    drive(1'b1, 1'b0, 1'b1, 32'h203, 1'b1, m_fetch ^ PAT);
    chk("same-cycle addr", imem_addr, 32'h200);
    chk("same-cycle nop", instruction_out, 32'h0);
    chk("same-cycle pulse", {31'b0, take_branch_addr_out}, 32'd1);
    fetch_ok();
    chk("same-cycle next", instruction_out, 32'hA5A5A7A5);

    // PC wrap at the top of the address space
    drive(1'b1, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b1, m_fetch ^ PAT);
    chk("top addr", imem_addr, 32'hFFFFFFFC);
    fetch_ok();
    chk("wrap instr", instruction_out, 32'h5A5A5A59);
    chk("wrap pc", pc_out, 32'hFFFFFFFC);
    chk("wrap addr", imem_addr, 32'h0);

    // Branch out of HOLD, then repeated redirects while draining
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
    drive(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    chk("hold branch addr", imem_addr, 32'h40);
    chk("hold branch nop", instruction_out, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 32'hC0, 1'b0, 32'h0);
    chk("rebranch pulse", {31'b0, take_branch_addr_out}, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 32'hE0, 1'b1, 32'hDEADBEEF);
    chk("rebranch ack addr", imem_addr, 32'hE0);
    fetch_ok();
    chk("rebranch instr", instruction_out, 32'hA5A5A545);
    drive(1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
    chk("drain-to-target addr", imem_addr, 32'h300);
    fetch_ok();
    idle();

    chk("squashed word seen", {31'b0, saw_squashed}, 32'd0);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction Fetch stage: owns the program counter, issues word reads to program memory over a request/acknowledge handshake, and delivers each fetched word with its PC to the IF/ID pipeline register. It supports hazard stalls, and branch redirects that arrive while a memory request is still outstanding. Instructions are always delivered in order, and fetched words from a squashed path never reach IF/ID.

## Interface
- RESET_PC, 32'h00000000, PC loaded on reset; word aligned
- clock  in  1  system clock, all state updates on rising edge
- nreset  in  1  synchronous, active-low reset
- stall  in  1  hazard-unit hold; PC and any fetched word are held
- take_branch  in  1  redirect request, sampled each cycle; overrides stall
- branch_addr  in  32  redirect target, valid with take_branch
- imem_req  out  1  read request to program memory
- imem_addr  out  32  read address; equals the PC register
- imem_ack  in  1  read data valid; exactly one per accepted request
- imem_rdata  in  32  read data, valid with imem_ack
- instruction_out  out  32  instruction word to IF/ID; 32'h00000000 (NOP) when no valid word
- pc_out  out  32  PC of instruction_out
- take_branch_addr_out  out  1  one-cycle pulse marking the first cycle after an accepted redirect

## Operation
- **States:**
  - RST: entered during reset.
  - REQ: request outstanding; imem_req=1.
  - HOLD: word captured during stall; imem_req=0.
  - DRAIN: squashed request outstanding; imem_req=1.
- **Request rule:** a request cannot be withdrawn once issued. imem_addr stays stable until imem_ack.
- **RST:**
  - Next state is REQ on the first cycle with nreset=1.
- **REQ, transitions evaluated in priority order:**
  - ack & take_branch: discard rdata. pc<=branch_addr. Pulse take_branch_addr_out. Stay in REQ.
  - !ack & take_branch: target<=branch_addr. Pulse take_branch_addr_out. Go to DRAIN.
  - ack & stall: hold_buf<=rdata, hold_pc<=pc. pc<=pc+4. Go to HOLD.
  - ack: instruction_out<=rdata, pc_out<=pc. pc<=pc+4. Stay in REQ.
  - otherwise: stay in REQ.
- **HOLD:**
  - take_branch: drop hold_buf. pc<=branch_addr. Pulse take_branch_addr_out. Go to REQ.
  - !stall: instruction_out<=hold_buf, pc_out<=hold_pc. Go to REQ.
  - stall: stay in HOLD.
- **DRAIN:**
  - New take_branch (ack or not): target<=branch_addr. Pulse take_branch_addr_out. If ack is present in the same cycle, the pending (stale) request completes here.
  - ack with no new branch: discard rdata. pc<=target. Go to REQ.
  - otherwise: stay in DRAIN.
- **NOP fill:** in every cycle without a delivery above, instruction_out<=32'h00000000. pc_out holds its value.
- **Arithmetic:** pc+4 is a modulo-2^32 add; 32'hFFFFFFFC wraps to 0.
- **Alignment:** branch_addr[1:0] is ignored and forced to 00.
- **Reset mid-operation:**
  - An outstanding request is abandoned and any ack arriving in RST is ignored.
  - The memory side must tolerate this; the bench drives no ack during RST.

## Timing
- **Reset values:**
  - imem_req=0
  - imem_addr=RESET_PC
  - instruction_out=0
  - pc_out=RESET_PC
  - take_branch_addr_out=0
  - state RST
- **First request:** imem_req rises one cycle after nreset deasserts.
- **Read latency:** imem_ack in cycle N gives instruction_out valid in cycle N+1.
- **Throughput:** with zero-wait memory (ack on the request cycle), one instruction per clock.
- **Redirect timing:**
  - imem_addr shows the target in the cycle after take_branch when no request is outstanding.
  - Otherwise it shows the target in the cycle after the stale ack.
- **take_branch_addr_out:** registered, high exactly one cycle per accepted redirect.
- **All outputs are registered.** The only exception is imem_addr, which is driven directly from the PC flop.

## Structure
- Package fetch_pkg holds:
  - the state enum (RST, REQ, HOLD, DRAIN)
  - NOP_WORD = 32'h00000000
  - PC_INCR = 32'd4
- Sub-module program_counter:
  - Holds the PC register and the next-PC mux (hold, +4, branch, target).
  - Has load/increment controls driven by the FSM.
- FSM, hold buffer and output registers live in instruction_fetch.

## Test plan
- Reset release, RESET_PC=0, ack every cycle, rdata=addr^32'hA5A5A5A5 -> instruction_out 32'hA5A5A5A5, 32'hA5A5A5A1, … from cycle 2; pc_out 0, 4, 8.
- Ack delayed 3 cycles per request -> imem_addr held stable across the wait; NOP between deliveries; pc_out increments by 4.
- stall asserted on an ack with rdata=32'h12345678 at pc=8, held for 2 cycles -> state HOLD, imem_req=0; on release, instruction_out=32'h12345678, pc_out=8, then fetch resumes at 12.
- take_branch with branch_addr=32'h100 while a request to 32'h10 is outstanding, ack 2 cycles later with 32'hDEADBEEF -> DEADBEEF never appears; next imem_addr=32'h100; take_branch_addr_out pulses once.
- take_branch with ack in the same cycle, branch_addr=32'h203 -> rdata discarded; imem_addr=32'h200 next cycle.
- PC at 32'hFFFFFFFC acked -> next imem_addr=32'h00000000.
